mem_line_fill: RTL and testbench

Cache-line fill controller sitting directly upstream of the long-latency data memory. It accepts a line request from the fetch/cache side and walks the memory one word at a time. The memory address is held stable until the memory's service-ready strobe, because the memory restarts its latency count on any address change. Each word is collected into a line buffer, and the whole line is returned with a single-cycle response strobe. A watchdog and a cancel input guard against a stalled or squashed access.

---
 rtl/mem_line_fill_pkg.sv | 26 ++
 rtl/mem_line_fill_buffer.sv | 32 +++
 rtl/mem_line_fill.sv | 125 ++++++++++++
 tb/tb_mem_line_fill.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_fill_pkg.sv
// Shared definitions for the line-fill controller: state encoding, clog2 helper
// and the default word/address widths shared with the data memory.
package mem_line_fill_pkg;

  localparam int MEM_DATA_W     = 16;
  localparam int MEM_ADDR_W     = 16;
  localparam int DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fillState_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int DEF_OFFSET_W = clog2(DEF_LINE_WORDS);

endpackage

// File: rtl/mem_line_fill_buffer.sv
// Line buffer: LINE_WORDS words of DATA_W bits with synchronous clear and a
// single indexed word write port; word 0 lands in the LSBs of line_o.
module fill_line_buffer
  import mem_line_fill_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear_i,
  input  logic                           wr_en_i,
  input  logic [clog2(LINE_WORDS)-1:0]   wr_idx_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  output logic [DATA_W*LINE_WORDS-1:0]   line_o
);

  logic [LINE_WORDS-1:0][DATA_W-1:0] words_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_q <= '0;
    end else if (clear_i) begin
      words_q <= '0;
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign line_o = words_q;

endmodule

// File: rtl/mem_line_fill.sv
// Cache-line fill controller: walks memory one word at a time, holding the
// address stable until each ready strobe, then returns the line in one strobe.
module mem_line_fill
  import mem_line_fill_pkg::*;
#(
  parameter int DATA_W     = MEM_DATA_W,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  input  logic                         cancel,
  output logic                         resp_valid,
  output logic [DATA_W*LINE_WORDS-1:0] resp_line,
  output logic                         resp_err,
  output logic [ADDR_W-1:0]            mem_address,
  input  logic [DATA_W-1:0]            mem_data_read,
  input  logic                         mem_service_ready
);

  localparam int OFF_W = clog2(LINE_WORDS);
  localparam int WD_W  = clog2(TIMEOUT + 1);
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_WORDS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  fillState_t        state_q, state_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [OFF_W-1:0]  wordIdx_q, wordIdx_d;
  logic [WD_W-1:0]   wdCnt_q, wdCnt_d;
  logic              respErr_q, respErr_d;
  logic              bufClear;
  logic              bufWrite;
  logic              accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      memAddr_q <= '0;
      wordIdx_q <= '0;
      wdCnt_q   <= '0;
      respErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      memAddr_q <= memAddr_d;
      wordIdx_q <= wordIdx_d;
      wdCnt_q   <= wdCnt_d;
      respErr_q <= respErr_d;
    end
  end

  // Cancel outranks both a ready strobe and the watchdog while filling.
  always_comb begin
    state_d   = state_q;
    memAddr_d = memAddr_q;
    wordIdx_d = wordIdx_q;
    wdCnt_d   = wdCnt_q;
    respErr_d = respErr_q;
    bufClear  = 1'b0;
    bufWrite  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_FILL;
          memAddr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wordIdx_d = '0;
          wdCnt_d   = '0;
          respErr_d = 1'b0;
          bufClear  = 1'b1;
        end
      end
      ST_FILL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (mem_service_ready) begin
          bufWrite = 1'b1;
          wdCnt_d  = '0;
          if (wordIdx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            wordIdx_d = wordIdx_q + OFF_W'(1);
            memAddr_d = memAddr_q + ADDR_W'(1);
          end
        end else if (wdCnt_q == WD_LIMIT) begin
          respErr_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wdCnt_d = wdCnt_q + WD_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready  = reset && (state_q == ST_IDLE) && !cancel;
    resp_valid = (state_q == ST_DONE);
  end

  assign accept      = req_valid && req_ready;
  assign mem_address = memAddr_q;
  assign resp_err    = respErr_q;

  fill_line_buffer #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) uLineBuffer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (bufClear),
    .wr_en_i   (bufWrite),
    .wr_idx_i  (wordIdx_q),
    .wr_data_i (mem_data_read),
    .line_o    (resp_line)
  );

endmodule

// File: tb/tb_mem_line_fill.sv
// Scoreboard bench for mem_line_fill: a latency-D memory model feeds the
// controller and each expected line is queued when its request is accepted.
module tb_mem_line_fill;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int TIMEOUT    = 15;
  localparam int MEM_D      = 3;
  localparam int LINE_W     = DATA_W * LINE_WORDS;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic              err;
    int                dueCycle;
  } resp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              cancel;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_line;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_read;
  logic              mem_service_ready = 1'b0;

  logic              memEnable;
  int                memCnt = 0;
  logic [ADDR_W-1:0] memLastAddr;
  int                cycleCnt = 0;
  logic              prevValid = 1'b0;
  resp_t             expQ[$];
  int                checkCount = 0;
  int                passCount = 0;

  mem_line_fill #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_ready         (req_ready),
    .cancel            (cancel),
    .resp_valid        (resp_valid),
    .resp_line         (resp_line),
    .resp_err          (resp_err),
    .mem_address       (mem_address),
    .mem_data_read     (mem_data_read),
    .mem_service_ready (mem_service_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
    return a + 16'h0060;
  endfunction

  // Memory restarts its latency count whenever the address changes.
  assign mem_data_read = memWord(mem_address);
  always @(negedge clk) begin
    memLastAddr <= mem_address;
    if (mem_address !== memLastAddr) begin
      memCnt            <= 1;
      mem_service_ready <= memEnable && (MEM_D == 1);
    end else begin
      memCnt            <= memCnt + 1;
      mem_service_ready <= memEnable && (memCnt + 1 == MEM_D);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (prevValid) checkOutput("pulseWidth", 64'd1, 64'd0);
      if (expQ.size() == 0) begin
        checkOutput("strayResp", 64'd1, 64'd0);
      end else begin
        checkOutput("respLine", 64'(resp_line), 64'(expQ[0].line));
        checkOutput("respErr", 64'(resp_err), 64'(expQ[0].err));
        checkOutput("respCycle", 64'(cycleCnt + 1), 64'(expQ[0].dueCycle));
        void'(expQ.pop_front());
      end
    end
    prevValid <= resp_valid;
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic expectResp,
                               input logic expErr, output int accCycle,
                               output logic [ADDR_W-1:0] addrAtAccept);
    int budget;
    logic [ADDR_W-1:0] base;
    resp_t e;
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    budget = 0;
    while (!req_ready && budget < 100) begin
      @(negedge clk);
      #2;
      budget++;
    end
    addrAtAccept = mem_address;
    if (!req_ready) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      accCycle  = -1;
      return;
    end
    accCycle = cycleCnt + 1;
    base     = addr & ~ADDR_W'(LINE_WORDS - 1);
    if (expectResp) begin
      e.line = '0;
      e.err  = expErr;
      if (!expErr) begin
        for (int i = 0; i < LINE_WORDS; i++) begin
          e.line[i*DATA_W +: DATA_W] = memWord(base + ADDR_W'(i));
        end
      end
      e.dueCycle = accCycle + (expErr ? TIMEOUT + 1 : LINE_WORDS * MEM_D + 1);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitWords(input int n, input logic [ADDR_W-1:0] base);
    int budget;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      do begin
        @(negedge clk);
        #1;
        budget++;
      end while (!mem_service_ready && budget < 30);
      if (!mem_service_ready) checkOutput("wordTimeout", 64'd0, 64'd1);
      else checkOutput("memAddr", 64'(mem_address), 64'(base + ADDR_W'(i)));
    end
  endtask

  task automatic waitScoreboard();
    int budget;
    budget = 0;
    while (expQ.size() != 0 && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (expQ.size() != 0) checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, observed running, expected done");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int acc1, acc2, dropCycle;
    logic [ADDR_W-1:0] seenAddr;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    cancel    = 1'b0;
    memEnable = 1'b1;
    #3;
    checkOutput("rstReady", 64'(req_ready), 64'd0);
    checkOutput("rstValid", 64'(resp_valid), 64'd0);
    checkOutput("rstLine", 64'(resp_line), 64'd0);
    checkOutput("rstErr", 64'(resp_err), 64'd0);
    checkOutput("rstAddr", 64'(mem_address), 64'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;

    $display("[TB] basic fill from 0x42");
    applyStimulus(16'h0042, 1'b1, 1'b0, acc1, seenAddr);
    waitWords(4, 16'h0040);
    waitScoreboard();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("lineHold", 64'(resp_line), 64'h00A3_00A2_00A1_00A0);
    checkOutput("addrHoldIdle", 64'(mem_address), 64'h43);

    $display("[TB] request blocked by cancel in idle");
    cancel    = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0024;
    #1 checkOutput("readyCancel", 64'(req_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("holdCancel", 64'(mem_address), 64'h43);
      checkOutput("readyCancelHeld", 64'(req_ready), 64'd0);
    end
    cancel    = 1'b0;
    dropCycle = cycleCnt;
    applyStimulus(16'h0024, 1'b1, 1'b0, acc1, seenAddr);
    checkOutput("acceptAfterCancel", 64'(acc1), 64'(dropCycle + 1));
    waitScoreboard();

    $display("[TB] watchdog abort");
    @(negedge clk);
    #1 memEnable = 1'b0;
    applyStimulus(16'h0063, 1'b1, 1'b1, acc1, seenAddr);
    waitScoreboard();
    @(negedge clk);
    #1;
    checkOutput("errHold", 64'(resp_err), 64'd1);
    checkOutput("lineZeroAfterErr", 64'(resp_line), 64'd0);
    memEnable = 1'b1;

    $display("[TB] cancel on second word");
    applyStimulus(16'h0071, 1'b0, 1'b0, acc1, seenAddr);
    waitWords(2, 16'h0070);
    cancel = 1'b1;
    @(negedge clk);
    #1 cancel = 1'b0;
    #1;
    checkOutput("readyAfterCancel", 64'(req_ready), 64'd1);
    checkOutput("addrAfterCancel", 64'(mem_address), 64'h71);
    checkOutput("validAfterCancel", 64'(resp_valid), 64'd0);
    applyStimulus(16'h0034, 1'b1, 1'b0, acc1, seenAddr);
    waitWords(4, 16'h0034);
    waitScoreboard();

    $display("[TB] reset during fill");
    applyStimulus(16'h0052, 1'b0, 1'b0, acc1, seenAddr);
    waitWords(2, 16'h0050);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midRstReady", 64'(req_ready), 64'd0);
    checkOutput("midRstValid", 64'(resp_valid), 64'd0);
    checkOutput("midRstLine", 64'(resp_line), 64'd0);
    checkOutput("midRstAddr", 64'(mem_address), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    #1 checkOutput("idleAfterReset", 64'(req_ready), 64'd1);

    $display("[TB] back-to-back requests");
    applyStimulus(16'h0010, 1'b1, 1'b0, acc1, seenAddr);
    applyStimulus(16'h001F, 1'b1, 1'b0, acc2, seenAddr);
    checkOutput("b2bAccept", 64'(acc2), 64'(acc1 + LINE_WORDS * MEM_D + 2));
    checkOutput("b2bIdleAddr", 64'(seenAddr), 64'h13);
    waitScoreboard();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
